// File: rtl/adc_sar_pkg.sv
// Shared definitions for the scanning SAR/OSR core: FSM state codes,
// widths of the latched osr/avg fields and clamp helpers.
package adc_sar_pkg;

  localparam int OSR_IN_W = 3;
  localparam int AVG_IN_W = 2;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_SAMPLE = 3'd1;
  localparam state_t ST_BITS   = 3'd2;
  localparam state_t ST_LSB    = 3'd3;
  localparam state_t ST_ACC    = 3'd4;
  localparam state_t ST_NEXT   = 3'd5;

  function automatic logic [OSR_IN_W-1:0] clamp_osr(input logic [OSR_IN_W-1:0] val,
                                                    input int max_val);
    if (int'(val) > max_val) return OSR_IN_W'(max_val);
    return val;
  endfunction

  function automatic logic [AVG_IN_W-1:0] clamp_avg(input logic [AVG_IN_W-1:0] val,
                                                    input int max_val);
    if (int'(val) > max_val) return AVG_IN_W'(max_val);
    return val;
  endfunction

endpackage

// File: rtl/adc_sar_lsb_vote.sv
// Counts comparator ones over 2^avg_log2 LSB compares; keep_bit includes the
// current cycle's comparator so it is valid together with done.
module adc_sar_lsb_vote #(
  parameter int MAX_AVG_LOG2 = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       count,
  input  logic       comp,
  input  logic [1:0] avg_log2,
  output logic       done,
  output logic       keep_bit
);

  localparam int CNT_W = MAX_AVG_LOG2 + 1;

  logic [CNT_W-1:0] ones;
  logic [CNT_W-1:0] cycles;
  logic [CNT_W-1:0] target;
  logic [CNT_W-1:0] ones_total;

  assign target     = CNT_W'(1) << avg_log2;
  assign done       = (cycles == (target - CNT_W'(1)));
  assign ones_total = ones + CNT_W'(comp);
  // Tie keeps the bit: 2*ones >= number of compares.
  assign keep_bit   = ({ones_total, 1'b0} >= {1'b0, target});

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      ones   <= '0;
      cycles <= '0;
    end else if (count) begin
      ones   <= ones_total;
      cycles <= cycles + CNT_W'(1);
    end
  end

endmodule

// File: rtl/adc_sar_scan_osr.sv
// Multi-channel SAR sequencer with voted LSB, oversampling accumulator and a
// one-entry valid/ready result buffer. Define ADC_OSR_ROUND_EN for result_avg_out.
module adc_sar_scan_osr
  import adc_sar_pkg::*;
#(
  parameter int RES_BITS     = 10,
  parameter int MAX_OSR_LOG2 = 4,
  parameter int MAX_AVG_LOG2 = 3,
  parameter int NUM_CH       = 4,
  parameter int CH_W         = $clog2(NUM_CH),
  parameter int ACC_W        = RES_BITS + MAX_OSR_LOG2
) (
  input  logic                clk_dig_in,
  input  logic                rst,
  input  logic                start_in,
  input  logic                continuous_in,
  input  logic [NUM_CH-1:0]   ch_mask_in,
  input  logic [2:0]          osr_log2_in,
  input  logic [1:0]          avg_log2_in,
  input  logic                comparator_in,
  output logic                sample_out,
  output logic [RES_BITS-1:0] dac_code_out,
  output logic [CH_W-1:0]     ch_sel_out,
  output logic                enable_loop_out,
  output logic                busy_out,
  output logic [ACC_W-1:0]    result_out,
  output logic [CH_W-1:0]     result_ch_out,
  output logic                result_valid_out,
  input  logic                result_ready_in,
  output logic                overrun_out
`ifdef ADC_OSR_ROUND_EN
  ,
  output logic [RES_BITS-1:0] result_avg_out
`endif
);

  localparam int BIDX_W = $clog2(RES_BITS);
  localparam int CNT_W  = MAX_OSR_LOG2 + 1;

  state_t                state;
  logic [NUM_CH-1:0]     mask_q;
  logic [OSR_IN_W-1:0]   osr_q;
  logic [AVG_IN_W-1:0]   avg_q;
  logic [CH_W-1:0]       ch_q;
  logic [RES_BITS-1:0]   code_q;
  logic [RES_BITS-1:0]   trial;
  logic [BIDX_W-1:0]     bit_idx;
  logic [ACC_W-1:0]      acc_q;
  logic [ACC_W-1:0]      acc_sum;
  logic [CNT_W-1:0]      conv_cnt;
  logic [CNT_W-1:0]      conv_next;
  logic [CNT_W-1:0]      conv_target;
  logic                  conv_done;
  logic                  push;
  logic                  load;
  logic                  start_ok;
  logic                  vote_done;
  logic                  vote_keep;
  logic [CH_W-1:0]       low_in;
  logic [CH_W-1:0]       low_q;
  logic [CH_W-1:0]       next_ch;
  logic                  next_found;
  logic [ACC_W-1:0]      result_q;
  logic [CH_W-1:0]       result_ch_q;
  logic                  valid_q;
  logic                  overrun_q;

  assign start_ok    = (state == ST_IDLE) && start_in && (|ch_mask_in);
  assign trial       = RES_BITS'(1) << bit_idx;
  assign acc_sum     = acc_q + ACC_W'(code_q);
  assign conv_next   = conv_cnt + CNT_W'(1);
  assign conv_target = CNT_W'(1) << osr_q;
  assign conv_done   = (conv_next >= conv_target);
  assign push        = (state == ST_ACC) && conv_done;
  assign load        = push && (!valid_q || result_ready_in);

  // Descending scan leaves the lowest matching channel in each result.
  always_comb begin
    low_in     = '0;
    low_q      = '0;
    next_ch    = '0;
    next_found = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_mask_in[i]) low_in = CH_W'(i);
      if (mask_q[i]) low_q = CH_W'(i);
      if (mask_q[i] && (i > int'(ch_q))) begin
        next_ch    = CH_W'(i);
        next_found = 1'b1;
      end
    end
  end

  adc_sar_lsb_vote #(
    .MAX_AVG_LOG2(MAX_AVG_LOG2)
  ) u_vote (
    .clk      (clk_dig_in),
    .rst      (rst),
    .clear    (state != ST_LSB),
    .count    (state == ST_LSB),
    .comp     (comparator_in),
    .avg_log2 (avg_q),
    .done     (vote_done),
    .keep_bit (vote_keep)
  );

  always_ff @(posedge clk_dig_in) begin
    if (rst) begin
      state    <= ST_IDLE;
      mask_q   <= '0;
      osr_q    <= '0;
      avg_q    <= '0;
      ch_q     <= '0;
      code_q   <= '0;
      bit_idx  <= '0;
      acc_q    <= '0;
      conv_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            mask_q   <= ch_mask_in;
            osr_q    <= clamp_osr(osr_log2_in, MAX_OSR_LOG2);
            avg_q    <= clamp_avg(avg_log2_in, MAX_AVG_LOG2);
            ch_q     <= low_in;
            acc_q    <= '0;
            conv_cnt <= '0;
            state    <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          code_q  <= '0;
          bit_idx <= BIDX_W'(RES_BITS - 1);
          state   <= ST_BITS;
        end
        ST_BITS: begin
          if (comparator_in) code_q <= code_q | trial;
          if (bit_idx == BIDX_W'(1)) state <= ST_LSB;
          else bit_idx <= bit_idx - BIDX_W'(1);
        end
        ST_LSB: begin
          if (vote_done) begin
            code_q[0] <= vote_keep;
            state     <= ST_ACC;
          end
        end
        ST_ACC: begin
          if (conv_done) begin
            acc_q    <= '0;
            conv_cnt <= '0;
            state    <= ST_NEXT;
          end else begin
            acc_q    <= acc_sum;
            conv_cnt <= conv_next;
            state    <= ST_SAMPLE;
          end
        end
        ST_NEXT: begin
          if (next_found) begin
            ch_q  <= next_ch;
            state <= ST_SAMPLE;
          end else if (continuous_in) begin
            ch_q  <= low_q;
            state <= ST_SAMPLE;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // A push into a held, unaccepted result is dropped and flagged.
  always_ff @(posedge clk_dig_in) begin
    if (rst) begin
      result_q    <= '0;
      result_ch_q <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (start_ok) overrun_q <= 1'b0;
      if (load) begin
        result_q    <= acc_sum;
        result_ch_q <= ch_q;
        valid_q     <= 1'b1;
      end else if (push) begin
        overrun_q <= 1'b1;
      end else if (valid_q && result_ready_in) begin
        valid_q <= 1'b0;
      end
    end
  end

`ifdef ADC_OSR_ROUND_EN
  logic [ACC_W:0]      rnd_bias;
  logic [ACC_W:0]      rnd_wide;
  logic [RES_BITS-1:0] avg_val;
  logic [RES_BITS-1:0] avg_res_q;

  always_comb begin
    rnd_bias = (osr_q == '0) ? '0 : ((ACC_W + 1)'(1) << (osr_q - OSR_IN_W'(1)));
    rnd_wide = ({1'b0, acc_sum} + rnd_bias) >> osr_q;
    avg_val  = (rnd_wide > (ACC_W + 1)'({RES_BITS{1'b1}})) ? '1 : rnd_wide[RES_BITS-1:0];
  end

  always_ff @(posedge clk_dig_in) begin
    if (rst) avg_res_q <= '0;
    else if (load) avg_res_q <= avg_val;
  end

  assign result_avg_out = avg_res_q;
`endif

  always_comb begin
    dac_code_out = '0;
    if (state == ST_BITS) dac_code_out = code_q | trial;
    else if (state == ST_LSB) dac_code_out = code_q | RES_BITS'(1);
  end

  assign sample_out       = (state == ST_SAMPLE);
  assign ch_sel_out       = ch_q;
  assign busy_out         = (state != ST_IDLE);
  assign enable_loop_out  = busy_out;
  assign result_out       = result_q;
  assign result_ch_out    = result_ch_q;
  assign result_valid_out = valid_q;
  assign overrun_out      = overrun_q;

endmodule

// File: tb/tb_adc_sar_scan_osr.sv
// Scoreboard bench for adc_sar_scan_osr: a comparator model answers the DAC,
// expected results are planned per scan from the conversion rules.
module tb_adc_sar_scan_osr;

  localparam int RES_BITS = 10;
  localparam int NUM_CH   = 4;
  localparam int CH_W     = 2;
  localparam int ACC_W    = 14;

  logic                clk_dig_in;
  logic                rst;
  logic                start_in;
  logic                continuous_in;
  logic [NUM_CH-1:0]   ch_mask_in;
  logic [2:0]          osr_log2_in;
  logic [1:0]          avg_log2_in;
  logic                comparator_in;
  logic                sample_out;
  logic [RES_BITS-1:0] dac_code_out;
  logic [CH_W-1:0]     ch_sel_out;
  logic                enable_loop_out;
  logic                busy_out;
  logic [ACC_W-1:0]    result_out;
  logic [CH_W-1:0]     result_ch_out;
  logic                result_valid_out;
  logic                result_ready_in;
  logic                overrun_out;
`ifdef ADC_OSR_ROUND_EN
  logic [RES_BITS-1:0] result_avg_out;
`endif

  adc_sar_scan_osr dut (
    .clk_dig_in       (clk_dig_in),
    .rst              (rst),
    .start_in         (start_in),
    .continuous_in    (continuous_in),
    .ch_mask_in       (ch_mask_in),
    .osr_log2_in      (osr_log2_in),
    .avg_log2_in      (avg_log2_in),
    .comparator_in    (comparator_in),
    .sample_out       (sample_out),
    .dac_code_out     (dac_code_out),
    .ch_sel_out       (ch_sel_out),
    .enable_loop_out  (enable_loop_out),
    .busy_out         (busy_out),
    .result_out       (result_out),
    .result_ch_out    (result_ch_out),
    .result_valid_out (result_valid_out),
    .result_ready_in  (result_ready_in),
    .overrun_out      (overrun_out)
`ifdef ADC_OSR_ROUND_EN
    ,
    .result_avg_out   (result_avg_out)
`endif
  );

  typedef struct {
    int         v;
    logic [7:0] pat;
  } conv_t;

  typedef struct {
    int sum;
    int ch;
    int avg;
  } exp_t;

  conv_t      conv_q[$];
  exp_t       exp_q[$];
  int         fixed_v[$];
  logic [7:0] fixed_pat[$];
  int         n_checks = 0;
  int         n_bad    = 0;
  int         n_popped = 0;
  bit         rand_ready = 0;

  initial begin
    clk_dig_in = 1'b0;
    forever #5 clk_dig_in = ~clk_dig_in;
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int lsb_vote(input logic [7:0] pat, input int n);
    int ones;
    ones = 0;
    for (int i = 0; i < n; i++) ones += int'(pat[i]);
    return (2 * ones >= n) ? 1 : 0;
  endfunction

  // Plans conversions in channel order and the results the consumer should see.
  task automatic plan_scan(input logic [3:0] mask, input int osr_in, input int avg_in, input int passes);
    int    osr;
    int    navg;
    int    sum;
    conv_t c;
    exp_t  e;
    osr  = (osr_in > 4) ? 4 : osr_in;
    navg = 1 << ((avg_in > 3) ? 3 : avg_in);
    for (int p = 0; p < passes; p++) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (mask[ch]) begin
          sum = 0;
          for (int k = 0; k < (1 << osr); k++) begin
            if (fixed_v.size() > 0) begin
              c.v   = fixed_v.pop_front();
              c.pat = (fixed_pat.size() > 0) ? fixed_pat.pop_front() : {8{c.v[0]}};
            end else begin
              c.v   = $urandom_range(0, 1023);
              c.pat = ($urandom_range(0, 1) == 0) ? {8{c.v[0]}} : 8'($urandom);
            end
            conv_q.push_back(c);
            sum += (c.v & ~1) | lsb_vote(c.pat, navg);
          end
          e.sum = sum;
          e.ch  = ch;
          e.avg = (osr == 0) ? sum : ((sum + (1 << (osr - 1))) >> osr);
          if (e.avg > 1023) e.avg = 1023;
          exp_q.push_back(e);
        end
      end
    end
  endtask

  // Config is scrambled after acceptance; the DUT must ignore it mid-scan.
  task automatic apply_stimulus(input logic [3:0] mask, input logic [2:0] osr, input logic [1:0] avg,
                                input logic cont);
    @(posedge clk_dig_in); #1;
    ch_mask_in    = mask;
    osr_log2_in   = osr;
    avg_log2_in   = avg;
    continuous_in = cont;
    start_in      = 1'b1;
    @(posedge clk_dig_in); #1;
    start_in      = 1'b0;
    ch_mask_in    = 4'($urandom);
    osr_log2_in   = 3'($urandom);
    avg_log2_in   = 2'($urandom);
  endtask

  task automatic wait_drain(input string name, input int budget, input bit need_empty);
    int cyc;
    int stall;
    cyc   = 0;
    stall = 0;
    while ((busy_out || (need_empty && exp_q.size() > 0)) && cyc < budget) begin
      @(posedge clk_dig_in); #1;
      cyc++;
      if (rand_ready) begin
        result_ready_in = (stall >= 3) || ($urandom_range(0, 3) != 0);
        stall = result_ready_in ? 0 : stall + 1;
      end
    end
    check_output(name, 32'(cyc < budget), 32'd1);
  endtask

  task automatic measure_latency(input string name, input int expected);
    int cyc;
    cyc = 0;
    while (!result_valid_out && cyc < 200) begin
      @(posedge clk_dig_in); #1;
      cyc++;
    end
    check_output(name, 32'(cyc), 32'(expected));
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_sample"}, 32'(sample_out), 32'd0);
    check_output({tag, "_dac"}, 32'(dac_code_out), 32'd0);
    check_output({tag, "_ch_sel"}, 32'(ch_sel_out), 32'd0);
    check_output({tag, "_enable_loop"}, 32'(enable_loop_out), 32'd0);
    check_output({tag, "_busy"}, 32'(busy_out), 32'd0);
    check_output({tag, "_result"}, 32'(result_out), 32'd0);
    check_output({tag, "_result_ch"}, 32'(result_ch_out), 32'd0);
    check_output({tag, "_valid"}, 32'(result_valid_out), 32'd0);
    check_output({tag, "_overrun"}, 32'(overrun_out), 32'd0);
`ifdef ADC_OSR_ROUND_EN
    check_output({tag, "_avg"}, 32'(result_avg_out), 32'd0);
`endif
  endtask

  // Comparator model: true SAR compare in BITS, planned noise pattern in LSB.
  initial begin
    conv_t cur;
    int    lsb_idx;
    cur.v         = 0;
    cur.pat       = '0;
    lsb_idx       = 0;
    comparator_in = 1'b0;
    forever begin
      @(negedge clk_dig_in);
      if (rst) begin
        comparator_in = 1'b0;
      end else if (sample_out) begin
        check_output("conversion_planned", 32'(conv_q.size() > 0), 32'd1);
        if (conv_q.size() > 0) cur = conv_q.pop_front();
        else begin
          cur.v   = 0;
          cur.pat = '0;
        end
        lsb_idx       = 0;
        comparator_in = 1'b0;
      end else if (busy_out && dac_code_out[0]) begin
        comparator_in = (lsb_idx < 8) ? cur.pat[lsb_idx] : 1'b0;
        lsb_idx++;
      end else begin
        comparator_in = (cur.v >= int'(dac_code_out));
      end
    end
  end

  // Monitor: each accepted result is popped once and compared.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_dig_in);
      if (!rst && result_valid_out && result_ready_in) begin
        check_output("result_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check_output("result_sum", 32'(result_out), 32'(e.sum));
          check_output("result_ch", 32'(result_ch_out), 32'(e.ch));
`ifdef ADC_OSR_ROUND_EN
          check_output("result_avg", 32'(result_avg_out), 32'(e.avg));
`endif
        end
        n_popped++;
      end
    end
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    n_bad++;
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          base;
    int          cyc;
    logic [3:0]  mask;
    logic [2:0]  osr;
    logic [1:0]  avg;

    rst             = 1'b1;
    start_in        = 1'b0;
    continuous_in   = 1'b0;
    ch_mask_in      = '0;
    osr_log2_in     = '0;
    avg_log2_in     = '0;
    result_ready_in = 1'b0;
    repeat (3) @(posedge clk_dig_in);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // Zero mask start is ignored.
    @(posedge clk_dig_in); #1;
    start_in = 1'b1;
    @(posedge clk_dig_in); #1;
    start_in = 1'b0;
    check_output("zero_mask_busy", 32'(busy_out), 32'd0);

    // Single conversion, V=806.
    fixed_v.push_back(806);
    plan_scan(4'b0001, 0, 0, 1);
    apply_stimulus(4'b0001, 3'd0, 2'd0, 1'b0);
    measure_latency("latency_osr0", 12);
    repeat (3) @(posedge clk_dig_in);
    #1;
    check_output("held_valid", 32'(result_valid_out), 32'd1);
    check_output("held_value", 32'(result_out), 32'h326);
    result_ready_in = 1'b1;
    wait_drain("drain_single", 100, 1'b1);
    @(posedge clk_dig_in); #1;
    check_output("valid_cleared", 32'(result_valid_out), 32'd0);
    check_output("idle_after_single", 32'(busy_out), 32'd0);

    // Oversampled: 972+812+4+0 = 1788.
    result_ready_in = 1'b0;
    fixed_v = '{972, 812, 4, 0};
    plan_scan(4'b0001, 2, 0, 1);
    apply_stimulus(4'b0001, 3'd2, 2'd0, 1'b0);
    measure_latency("latency_osr2", 48);
    check_output("osr2_value", 32'(result_out), 32'd1788);
    result_ready_in = 1'b1;
    wait_drain("drain_osr2", 100, 1'b1);

    // LSB vote: tie keeps, minority drops.
    fixed_v.push_back(812);
    fixed_pat.push_back(8'b0000_0011);
    plan_scan(4'b0001, 0, 2, 1);
    apply_stimulus(4'b0001, 3'd0, 2'd2, 1'b0);
    wait_drain("drain_vote_tie", 100, 1'b1);
    fixed_v.push_back(812);
    fixed_pat.push_back(8'b0000_0001);
    plan_scan(4'b0001, 0, 2, 1);
    apply_stimulus(4'b0001, 3'd0, 2'd2, 1'b0);
    wait_drain("drain_vote_min", 100, 1'b1);

    // Continuous scan over channels 1 and 3, stopped during the fourth conversion.
    plan_scan(4'b1010, 0, 0, 2);
    base = n_popped;
    apply_stimulus(4'b1010, 3'd0, 2'd0, 1'b1);
    cyc = 0;
    while (n_popped < base + 3 && cyc < 400) begin
      @(posedge clk_dig_in); #1;
      cyc++;
    end
    check_output("continuous_progress", 32'(cyc < 400), 32'd1);
    continuous_in = 1'b0;
    wait_drain("drain_continuous", 200, 1'b1);
    check_output("continuous_conv_count", 32'(conv_q.size()), 32'd0);

    // Overrun: consumer stalled, second channel's result dropped.
    result_ready_in = 1'b0;
    plan_scan(4'b0011, 0, 0, 1);
    void'(exp_q.pop_back());
    apply_stimulus(4'b0011, 3'd0, 2'd0, 1'b0);
    wait_drain("idle_overrun", 200, 1'b0);
    check_output("overrun_set", 32'(overrun_out), 32'd1);
    check_output("overrun_held_valid", 32'(result_valid_out), 32'd1);
    result_ready_in = 1'b1;
    wait_drain("drain_overrun", 50, 1'b1);
    check_output("overrun_sticky", 32'(overrun_out), 32'd1);
    plan_scan(4'b0100, 0, 1, 1);
    apply_stimulus(4'b0100, 3'd0, 2'd1, 1'b0);
    check_output("overrun_cleared_by_start", 32'(overrun_out), 32'd0);
    wait_drain("drain_after_overrun", 100, 1'b1);

    // Reset in the middle of BITS with a held result on channel 2.
    result_ready_in = 1'b0;
    plan_scan(4'b0100, 0, 0, 1);
    apply_stimulus(4'b0100, 3'd0, 2'd0, 1'b0);
    wait_drain("idle_before_reset", 100, 1'b0);
    plan_scan(4'b0100, 1, 0, 1);
    apply_stimulus(4'b0100, 3'd1, 2'd0, 1'b0);
    repeat (3) @(posedge clk_dig_in);
    #1;
    rst = 1'b1;
    @(posedge clk_dig_in); #1;
    check_all_zero("mid_reset");
    rst = 1'b0;
    exp_q.delete();
    conv_q.delete();
    result_ready_in = 1'b1;
    plan_scan(4'b0010, 1, 1, 1);
    apply_stimulus(4'b0010, 3'd1, 2'd1, 1'b0);
    wait_drain("drain_after_reset", 200, 1'b1);

    // Randomised scans with a stalling consumer.
    rand_ready = 1;
    for (int it = 0; it < 10; it++) begin
      mask = 4'($urandom_range(1, 15));
      osr  = 3'($urandom_range(0, 7));
      avg  = 2'($urandom_range(0, 3));
      plan_scan(mask, int'(osr), int'(avg), 1);
      apply_stimulus(mask, osr, avg, 1'b0);
      wait_drain("drain_random", 3000, 1'b1);
    end
    rand_ready = 0;
    check_output("random_conv_count", 32'(conv_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/adc_sar_scan_osr.md
Name: adc_sar_scan_osr

Overview:
Parametrised successor to the single-channel SAR/OSR digital core. It sequences SAR conversions across up to NUM_CH channels and sets the trial code bit by bit. The LSB decision is taken by majority vote over repeated comparisons. Each channel accumulates 2^osr_log2 conversions, and the sum is delivered through a one-entry valid/ready result buffer; the block sits between comparator/cap-DAC and the register interface.

Parameters:
RES_BITS, 10, SAR resolution in bits
MAX_OSR_LOG2, 4, maximum log2 of oversampling count
MAX_AVG_LOG2, 3, maximum log2 of LSB repeat count
NUM_CH, 4, number of input channels
CH_W, $clog2(NUM_CH), channel index width (derived)
ACC_W, RES_BITS+MAX_OSR_LOG2, accumulator/result width (derived)

Ports:
clk_dig_in  in  1  digital clock
rst  in  1  synchronous active-high reset
start_in  in  1  start scan (sampled in IDLE only)
continuous_in  in  1  1: rescan after last channel
ch_mask_in  in  NUM_CH  enabled channels, latched at start
osr_log2_in  in  3  conversions per result = 2^min(val,MAX_OSR_LOG2), latched at start
avg_log2_in  in  2  LSB compares = 2^min(val,MAX_AVG_LOG2), latched at start
comparator_in  in  1  1 = input >= DAC code
sample_out  out  1  sampling phase
dac_code_out  out  RES_BITS  trial code to cap matrix
ch_sel_out  out  CH_W  channel being converted
enable_loop_out  out  1  clock-loop enable, equals busy
busy_out  out  1  FSM not IDLE
result_out  out  ACC_W  zero-extended sum of conversions
result_ch_out  out  CH_W  channel of result_out
result_valid_out  out  1  result held
result_ready_in  in  1  consumer accepts
overrun_out  out  1  sticky: result dropped

Behaviour:
- Reset is synchronous. On reset every output is 0 and the FSM goes to IDLE. It takes effect on the next edge even mid-conversion; the accumulator, buffer and overrun flag are cleared.
- FSM states: IDLE, SAMPLE, BITS, LSB, ACC, NEXT.
- IDLE:
  - start_in=1 with nonzero ch_mask_in latches the config, clears overrun_out, selects the lowest enabled channel and goes to SAMPLE.
  - start_in=1 with a zero mask is ignored.
- SAMPLE: 1 cycle; sample_out=1, dac_code_out=0.
- BITS: RES_BITS-1 cycles, MSB first.
  - dac_code_out = decided bits | trial bit.
  - The comparator is sampled at the cycle end; 1 keeps the trial bit.
- LSB: 2^avg cycles with the trial LSB set; ones are counted.
  - The bit is kept if 2*ones >= 2^avg, so a tie keeps it.
  - avg=0 gives a plain single compare.
- ACC: 1 cycle. The code is added to the accumulator and the conversion counter is incremented.
  - If the counter is below 2^osr, go to SAMPLE (same channel).
  - Otherwise push the sum to the buffer, clear the accumulator and go to NEXT.
- NEXT: 1 cycle.
  - Selects the next enabled channel above the current one → SAMPLE.
  - After the highest enabled channel: wraps to the lowest enabled channel if continuous_in=1 (sampled here), else → IDLE.
- Cycles per conversion = 1 + (RES_BITS-1) + 2^avg + 1, i.e. 12 at defaults with avg=0.
- Accumulator never overflows by construction (ACC_W sized for the maximum OSR).
- Result buffer:
  - A push with the buffer empty, or in the same cycle as valid&&ready, loads the buffer and sets valid.
  - A push while valid&&!ready drops the new result, keeps the old one and sets overrun_out.
  - valid clears on valid&&ready with no push.
  - result_out and result_ch_out are stable while valid.
- Config inputs, start_in and mask changes outside IDLE are ignored.

Optional Feature:
ADC_OSR_ROUND_EN:
- Defined: adds output port result_avg_out (RES_BITS) = (sum + 2^(osr-1)) >> osr, saturated to 2^RES_BITS-1; equals the sum when osr=0. It is registered with result_out and reset to 0.
- Undefined: port and logic absent.

Decomposition:
- Package adc_sar_pkg: FSM state enum, osr/avg field widths, clamp helper functions.
- Sub-module adc_sar_lsb_vote: ones counter and majority compare for the LSB phase (count, clear, done, keep_bit).

Test Plan:
- osr=0, avg=0, mask=0001, comparator model V=806 → after 12 cycles result_out=0x326, result_ch_out=0, valid until ready; busy drops.
- osr=2, mask=0001, V=972,812,4,0 per conversion → single result 0x6FC (1788) after 48 cycles.
- avg=2, upper bits converge to 0x32C; LSB compares 1,1,0,0 → 0x32D; LSB compares 1,0,0,0 → 0x32C.
- mask=1010, continuous=1, ready=1 → result_ch_out sequence 1,3,1,3; drop continuous → idles after channel 3.
- ready=0, mask=0011 → ch0 result held, ch1 result dropped, overrun_out=1; the next start clears it.
- rst pulsed in the middle of BITS → next cycle all outputs 0, IDLE; a new start converts correctly.
